// File: rtl/w0rm_start_stop_initiator.sv
// w0rm_start_stop_initiator
// Issues one start pulse per accepted request to a start/stop timer-style
// slave. It then counts WAIT cycles until the slave answers with stop, and
// returns the request tag and the elapsed count as a response.
//
// Optional feature: define W0RM_INITIATOR_TIMEOUT_EN to enable the watchdog.
// The watchdog ends WAIT after TIMEOUT cycles and reports rsp_timeout=1.
// When the macro is undefined, WAIT ends only on stop and rsp_timeout stays 0.
//
// Handshakes (strict valid/ready):
//   - A transfer happens on a posedge where both valid and ready are 1.
//   - Request side: req_ready depends only on the state.
//   - Response side: rsp_valid, rsp_tag, rsp_cycles and rsp_timeout are
//     held stable until the response is taken.
//
// dbg_state_o exposes the FSM state for checkers:
//   0 = IDLE, 1 = START, 2 = WAIT, 3 = RESP.
module w0rm_start_stop_initiator #(
  parameter int TAG_WIDTH = 4,
  parameter int CNT_WIDTH = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 start,
  input  logic                 stop,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [TAG_WIDTH-1:0] rsp_tag,
  output logic [CNT_WIDTH-1:0] rsp_cycles,
  output logic                 rsp_timeout,
  output logic                 stray_stop,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                 state_q;
  logic                   start_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic                   rsp_valid_q;
  logic [CNT_WIDTH-1:0]   rsp_cycles_q;
  logic                   rsp_timeout_q;
  logic                   stray_q;

  logic [CNT_WIDTH-1:0]   cnt_d;
  logic                   timeout_hit;

  // Saturating increment.
  // This value is the count including the current WAIT cycle.
  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);

`ifdef W0RM_INITIATOR_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
  // The watchdog fires in the WAIT cycle that brings the count to TIMEOUT.
  assign timeout_hit = (cnt_d == TIMEOUT_C);
`else
  logic unused_timeout;
  // Without the watchdog, TIMEOUT is accepted but has no effect.
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  // Main FSM with registered outputs.
  // When stop and the watchdog fire in the same WAIT cycle, stop wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      start_q       <= 1'b0;
      cnt_q         <= '0;
      tag_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_cycles_q  <= '0;
      rsp_timeout_q <= 1'b0;
      stray_q       <= 1'b0;
    end else begin
      // A stop sampled outside WAIT does not affect the FSM.
      // It only raises a one-cycle flag.
      stray_q <= stop && (state_q != ST_WAIT);
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            tag_q   <= req_tag;
            start_q <= 1'b1;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          start_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_d;
          if (stop) begin
            rsp_valid_q   <= 1'b1;
            rsp_cycles_q  <= cnt_d;
            rsp_timeout_q <= 1'b0;
            state_q       <= ST_RESP;
          end else if (timeout_hit) begin
            rsp_valid_q   <= 1'b1;
            rsp_cycles_q  <= cnt_d;
            rsp_timeout_q <= 1'b1;
            state_q       <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Returning to IDLE ensures no new request is taken
          // in the cycle where the response handshakes.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign start       = start_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_tag     = tag_q;
  assign rsp_cycles  = rsp_cycles_q;
  assign rsp_timeout = rsp_timeout_q;
  assign stray_stop  = stray_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/w0rm_start_stop_initiator.md
W0RM_START_STOP_INITIATOR -- requirements
Module: w0rm_start_stop_initiator

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 4: width of request/response tag.
REQ-002 SHALL have parameter CNT_WIDTH, default 8: width of the elapsed-cycle counter.
REQ-003 SHALL have parameter TIMEOUT, default 200: watchdog limit in WAIT cycles; TIMEOUT SHALL be 1 .. 2^CNT_WIDTH-1.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  upstream requests one timed operation.
REQ-007 SHALL have port req_ready  output  1  block accepts a request this cycle.
REQ-008 SHALL have port req_tag  input  TAG_WIDTH  opaque ID returned with the response.
REQ-009 SHALL have port start  output  1  start pulse to a start/stop timer-style slave.
REQ-010 SHALL have port stop  input  1  completion pulse from the slave.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  downstream accepts the response.
REQ-013 SHALL have port rsp_tag  output  TAG_WIDTH  tag captured at request acceptance.
REQ-014 SHALL have port rsp_cycles  output  CNT_WIDTH  WAIT cycles elapsed, up to and including the stop cycle.
REQ-015 SHALL have port rsp_timeout  output  1  operation ended by watchdog, not by stop.
REQ-016 SHALL have port stray_stop  output  1  one-cycle flag: stop sampled outside WAIT.

Function
REQ-017 SHALL implement FSM states IDLE, START, WAIT, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE, decoded from state alone.
REQ-019 IDLE: req_valid=1 SHALL capture req_tag and go to START next cycle; otherwise stay in IDLE.
REQ-020 START: start SHALL be 1 for exactly this one cycle; the counter SHALL clear to 0; the next state SHALL be WAIT.
REQ-021 start SHALL be 0 in every state other than START.
REQ-022 WAIT: each cycle the counter SHALL increment by 1, saturating at 2^CNT_WIDTH-1.
REQ-023 WAIT with stop=1: go to RESP; rsp_cycles = counter+1; rsp_timeout=0.
REQ-024 WAIT with stop=0 and counter+1 == TIMEOUT: go to RESP; rsp_cycles=TIMEOUT; rsp_timeout=1.
REQ-025 If stop=1 in the same cycle the timeout would fire, stop SHALL win and rsp_timeout SHALL be 0.
REQ-026 RESP: rsp_valid SHALL be 1; rsp_tag, rsp_cycles and rsp_timeout SHALL remain stable until rsp_valid & rsp_ready, then the FSM SHALL return to IDLE.
REQ-027 A new request SHALL NOT be accepted in the cycle the response handshakes; the minimum request-to-request interval is 4 cycles.
REQ-028 stop=1 in IDLE, START or RESP SHALL be ignored by the FSM and SHALL assert stray_stop for the following cycle only.

Reset
REQ-029 reset SHALL force IDLE, counter=0, start=0, rsp_valid=0, rsp_timeout=0, rsp_cycles=0, rsp_tag=0, stray_stop=0 at the next posedge clk, from any state.
REQ-030 reset SHALL take priority over every other input in the same cycle.
REQ-031 After reset mid-operation, a late stop from the unreset slave SHALL be reported only as stray_stop.

Configuration
REQ-032 Macro W0RM_INITIATOR_TIMEOUT_EN defined: the watchdog SHALL operate per REQ-024/025.
REQ-033 Macro W0RM_INITIATOR_TIMEOUT_EN undefined: the watchdog logic SHALL be omitted; WAIT SHALL exit only on stop; rsp_timeout SHALL be tied 0; the TIMEOUT parameter SHALL have no effect.

Verification
REQ-034 Slave = start/stop timer, LOAD=0, LIMIT=2; request tag 0x5 -> start high 1 cycle; rsp_valid with rsp_tag=0x5, rsp_cycles=4, rsp_timeout=0.
REQ-035 TIMEOUT=10, stop held 0, macro defined -> rsp_valid after 10 WAIT cycles with rsp_cycles=10 and rsp_timeout=1; the same test with the macro undefined -> no response after 500 cycles.
REQ-036 TIMEOUT=10 with stop asserted in the 10th WAIT cycle -> rsp_cycles=10 and rsp_timeout=0.
REQ-037 rsp_ready held 0 for 20 cycles during RESP -> rsp_* outputs stable, req_ready=0, stop pulse asserts stray_stop for 1 cycle.
REQ-038 reset asserted in the 2nd WAIT cycle -> next cycle IDLE with all outputs 0; the slave's later stop -> stray_stop=1 for 1 cycle and no response.
REQ-039 Back-to-back requests with tags 1, 2, 3 and rsp_ready tied 1 -> three responses in order, each with rsp_cycles=4.
